// File: rtl/idex_stage_pkg.sv
// rtl/idex_stage_pkg.sv - shared RV32I constants and the operand forwarding priority function
package r200_pkg;

   localparam int XLEN = 32;
   localparam int REGW = 5;

   typedef enum logic [2:0] {
      F3_ADD  = 3'b000,
      F3_SLL  = 3'b001,
      F3_SLT  = 3'b010,
      F3_SLTU = 3'b011,
      F3_XOR  = 3'b100,
      F3_SR   = 3'b101,
      F3_OR   = 3'b110,
      F3_AND  = 3'b111
   } funct3_e;

   // x0 is hard zero; otherwise the youngest producer (EX/MEM) beats MEM/WB,
   // which beats the value already held or read from the register file.
   function automatic logic [XLEN-1:0] fwd_value(
      input logic [REGW-1:0] rs,
      input logic [XLEN-1:0] base,
      input logic            exm_wb_en,
      input logic [REGW-1:0] exm_rd,
      input logic [XLEN-1:0] exm_result,
      input logic            mwb_wb_en,
      input logic [REGW-1:0] mwb_rd,
      input logic [XLEN-1:0] mwb_result
   );
      if (rs == '0)
         return '0;
      else if (exm_wb_en && (exm_rd == rs))
         return exm_result;
      else if (mwb_wb_en && (mwb_rd == rs))
         return mwb_result;
      else
         return base;
   endfunction

endpackage

// File: rtl/idex_stage_if.sv
// rtl/idex_stage_if.sv - decode-side and execute-side handshake bundle of the ID/EX register
interface idex_stage_if;
   import r200_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [REGW-1:0] in_rs1;
   logic [REGW-1:0] in_rs2;
   logic [REGW-1:0] in_rd;
   logic [XLEN-1:0] in_rs1_val;
   logic [XLEN-1:0] in_rs2_val;
   logic [XLEN-1:0] in_imm;
   logic            in_use_imm;
   logic [2:0]      in_funct3;
   logic            in_b30;
   logic            in_wb_en;
   logic            in_is_load;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [2:0]      alu_op;
   logic            alu_control;
   logic            alu_lt;
   logic            alu_ltu;
   logic [XLEN-1:0] out_pc;
   logic [REGW-1:0] out_rd;
   logic            out_wb_en;
   logic            out_is_load;

   // Environment side: drives decode fields and execute backpressure.
   modport master (
      output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_rs1_val, in_rs2_val,
             in_imm, in_use_imm, in_funct3, in_b30, in_wb_en, in_is_load,
             out_ready,
      input  in_ready, out_valid, alu_a, alu_b, alu_op, alu_control,
             alu_lt, alu_ltu, out_pc, out_rd, out_wb_en, out_is_load
   );

   // Pipeline register side.
   modport slave (
      input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_rs1_val, in_rs2_val,
             in_imm, in_use_imm, in_funct3, in_b30, in_wb_en, in_is_load,
             out_ready,
      output in_ready, out_valid, alu_a, alu_b, alu_op, alu_control,
             alu_lt, alu_ltu, out_pc, out_rd, out_wb_en, out_is_load
   );

endinterface

// File: rtl/idex_stage_fwd.sv
// rtl/idex_stage_fwd.sv - combinational operand forwarding mux for one source register
module operand_fwd
   import r200_pkg::*;
(
   input  logic [REGW-1:0] rs,
   input  logic [XLEN-1:0] base,
   input  logic            exm_wb_en,
   input  logic [REGW-1:0] exm_rd,
   input  logic [XLEN-1:0] exm_result,
   input  logic            mwb_wb_en,
   input  logic [REGW-1:0] mwb_rd,
   input  logic [XLEN-1:0] mwb_result,
   output logic [XLEN-1:0] value,
   output logic            match_exm,
   output logic            match_mwb
);

   // Match flags exclude x0 so callers can use them directly for hazards and snooping.
   assign match_exm = exm_wb_en && (exm_rd == rs) && (rs != '0);
   assign match_mwb = mwb_wb_en && (mwb_rd == rs) && (rs != '0);

   assign value = fwd_value(rs, base, exm_wb_en, exm_rd, exm_result,
                            mwb_wb_en, mwb_rd, mwb_result);

endmodule

// File: rtl/idex_stage.sv
// rtl/idex_stage.sv - ID/EX pipeline register with forwarding, load-use stall and compare flags
module idex_stage
   import r200_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   idex_stage_if.slave     io,
   input  logic            exm_wb_en,
   input  logic [REGW-1:0] exm_rd,
   input  logic [XLEN-1:0] exm_result,
   input  logic            exm_data_ok,
   input  logic            mwb_wb_en,
   input  logic [REGW-1:0] mwb_rd,
   input  logic [XLEN-1:0] mwb_result,
   input  logic            flush
);

   logic            valid_q;
   logic [XLEN-1:0] pc_q;
   logic [REGW-1:0] rs1_q;
   logic [REGW-1:0] rs2_q;
   logic [REGW-1:0] rd_q;
   logic [XLEN-1:0] r1_q;
   logic [XLEN-1:0] r2_q;
   logic [XLEN-1:0] imm_q;
   logic            use_imm_q;
   logic [2:0]      funct3_q;
   logic            b30_q;
   logic            wb_en_q;
   logic            is_load_q;

   logic [XLEN-1:0] a_val;
   logic [XLEN-1:0] b_val;
   logic            m1_exm;
   logic            m1_mwb;
   logic            m2_exm;
   logic            m2_mwb;
   logic            hz;
   logic            capture;
   logic            out_fire;
   logic [XLEN-1:0] cap_r1;
   logic [XLEN-1:0] cap_r2;

   // Live forwarding onto the held entry, so a producer that lands while we
   // sit here is seen in the same cycle.
   operand_fwd u_fwd_rs1 (
      .rs         (rs1_q),
      .base       (r1_q),
      .exm_wb_en  (exm_wb_en),
      .exm_rd     (exm_rd),
      .exm_result (exm_result),
      .mwb_wb_en  (mwb_wb_en),
      .mwb_rd     (mwb_rd),
      .mwb_result (mwb_result),
      .value      (a_val),
      .match_exm  (m1_exm),
      .match_mwb  (m1_mwb)
   );

   operand_fwd u_fwd_rs2 (
      .rs         (rs2_q),
      .base       (r2_q),
      .exm_wb_en  (exm_wb_en),
      .exm_rd     (exm_rd),
      .exm_result (exm_result),
      .mwb_wb_en  (mwb_wb_en),
      .mwb_rd     (mwb_rd),
      .mwb_result (mwb_result),
      .value      (b_val),
      .match_exm  (m2_exm),
      .match_mwb  (m2_mwb)
   );

   // Incoming operands are resolved with the same priority before being stored.
   assign cap_r1 = fwd_value(io.in_rs1, io.in_rs1_val, exm_wb_en, exm_rd, exm_result,
                             mwb_wb_en, mwb_rd, mwb_result);
   assign cap_r2 = fwd_value(io.in_rs2, io.in_rs2_val, exm_wb_en, exm_rd, exm_result,
                             mwb_wb_en, mwb_rd, mwb_result);

   // A load in EX/MEM without data yet blocks issue; rs2 only matters without an immediate.
   assign hz       = valid_q && !exm_data_ok && (m1_exm || (!use_imm_q && m2_exm));
   assign out_fire = io.out_valid && io.out_ready;
   assign capture  = io.in_valid && io.in_ready && !flush;

   assign io.out_valid   = valid_q && !hz;
   assign io.in_ready    = !valid_q || out_fire;
   assign io.alu_a       = a_val;
   assign io.alu_b       = use_imm_q ? imm_q : b_val;
   assign io.alu_op      = funct3_q;
   // Bit 30 is an immediate bit on I-type ALU ops except shifts, so ignore it there.
   assign io.alu_control = b30_q && (!use_imm_q || (funct3_q == F3_SR));
   assign io.alu_lt      = $signed(io.alu_a) < $signed(io.alu_b);
   assign io.alu_ltu     = io.alu_a < io.alu_b;
   assign io.out_pc      = pc_q;
   assign io.out_rd      = rd_q;
   assign io.out_wb_en   = wb_en_q;
   assign io.out_is_load = is_load_q;

   // Entry occupancy, field capture, and MEM/WB snooping of a held entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         r1_q      <= '0;
         r2_q      <= '0;
         imm_q     <= '0;
         use_imm_q <= 1'b0;
         funct3_q  <= '0;
         b30_q     <= 1'b0;
         wb_en_q   <= 1'b0;
         is_load_q <= 1'b0;
      end else begin
         if (flush)
            valid_q <= 1'b0;
         else if (capture)
            valid_q <= 1'b1;
         else if (out_fire)
            valid_q <= 1'b0;

         if (capture) begin
            pc_q      <= io.in_pc;
            rs1_q     <= io.in_rs1;
            rs2_q     <= io.in_rs2;
            rd_q      <= io.in_rd;
            r1_q      <= cap_r1;
            r2_q      <= cap_r2;
            imm_q     <= io.in_imm;
            use_imm_q <= io.in_use_imm;
            funct3_q  <= io.in_funct3;
            b30_q     <= io.in_b30;
            wb_en_q   <= io.in_wb_en;
            is_load_q <= io.in_is_load;
         end else if (valid_q) begin
            if (m1_mwb)
               r1_q <= mwb_result;
            if (m2_mwb)
               r2_q <= mwb_result;
         end
      end
   end

endmodule

// File: tb/tb_idex_stage.sv
// tb/tb_idex_stage.sv - scoreboard bench for the ID/EX pipeline register
module tb_idex_stage;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic        ctrl;
      logic        lt;
      logic        ltu;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        wb;
      logic        ld;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        exm_wb_en;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        exm_data_ok;
   logic        mwb_wb_en;
   logic [4:0]  mwb_rd;
   logic [31:0] mwb_result;
   logic        flush;

   int   errors = 0;
   int   checks = 0;
   exp_t sbq[$];
   exp_t e;

   idex_stage_if io ();

   idex_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .io          (io),
      .exm_wb_en   (exm_wb_en),
      .exm_rd      (exm_rd),
      .exm_result  (exm_result),
      .exm_data_ok (exm_data_ok),
      .mwb_wb_en   (mwb_wb_en),
      .mwb_rd      (mwb_rd),
      .mwb_result  (mwb_result),
      .flush       (flush)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t make_exp(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] op, input logic b30,
                                     input logic use_imm, input logic [31:0] pc,
                                     input logic [4:0] rd, input logic wb, input logic ld);
      exp_t x;
      x.a    = a;
      x.b    = b;
      x.op   = op;
      x.ctrl = b30 && (!use_imm || (op == 3'b101));
      x.lt   = $signed(a) < $signed(b);
      x.ltu  = a < b;
      x.pc   = pc;
      x.rd   = rd;
      x.wb   = wb;
      x.ld   = ld;
      return x;
   endfunction

   // Every accepted output is matched against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && io.out_valid && io.out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected pc=%h: output accepted with nothing expected", io.out_pc);
            end else begin
               e = sbq.pop_front();
               if (io.alu_a !== e.a || io.alu_b !== e.b || io.alu_op !== e.op ||
                   io.alu_control !== e.ctrl || io.alu_lt !== e.lt || io.alu_ltu !== e.ltu ||
                   io.out_pc !== e.pc || io.out_rd !== e.rd || io.out_wb_en !== e.wb ||
                   io.out_is_load !== e.ld) begin
                  errors++;
                  $display("FAIL sb_out got a=%h b=%h op=%0d ctl=%b lt=%b ltu=%b pc=%h rd=%0d wb=%b ld=%b exp a=%h b=%h op=%0d ctl=%b lt=%b ltu=%b pc=%h rd=%0d wb=%b ld=%b",
                           io.alu_a, io.alu_b, io.alu_op, io.alu_control, io.alu_lt, io.alu_ltu,
                           io.out_pc, io.out_rd, io.out_wb_en, io.out_is_load,
                           e.a, e.b, e.op, e.ctrl, e.lt, e.ltu, e.pc, e.rd, e.wb, e.ld);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_clear();
      exm_wb_en   = 1'b0;
      exm_rd      = '0;
      exm_result  = '0;
      exm_data_ok = 1'b1;
      mwb_wb_en   = 1'b0;
      mwb_rd      = '0;
      mwb_result  = '0;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic use_imm, input logic [2:0] f3,
                        input logic b30, input logic wb, input logic ld);
      io.in_valid   = 1'b1;
      io.in_pc      = pc;
      io.in_rs1     = rs1;
      io.in_rs2     = rs2;
      io.in_rd      = rd;
      io.in_rs1_val = v1;
      io.in_rs2_val = v2;
      io.in_imm     = imm;
      io.in_use_imm = use_imm;
      io.in_funct3  = f3;
      io.in_b30     = b30;
      io.in_wb_en   = wb;
      io.in_is_load = ld;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      io.out_ready = 1'b1;
      bus_clear();
      drive('0, '0, '0, '0, '0, '0, '0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      io.in_valid = 1'b0;
      step();
      step();
      #1;
      checks++;
      if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_hs out_valid=%b in_ready=%b required 0/1", io.out_valid, io.in_ready);
      end
      checks++;
      if (io.alu_a !== 32'h0 || io.alu_b !== 32'h0 || io.alu_op !== 3'h0 || io.alu_control !== 1'b0 ||
          io.alu_lt !== 1'b0 || io.alu_ltu !== 1'b0 || io.out_pc !== 32'h0 || io.out_rd !== 5'h0 ||
          io.out_wb_en !== 1'b0 || io.out_is_load !== 1'b0) begin
         errors++;
         $display("FAIL reset_fields a=%h b=%h op=%0d ctl=%b lt=%b ltu=%b pc=%h rd=%0d wb=%b ld=%b required all zero",
                  io.alu_a, io.alu_b, io.alu_op, io.alu_control, io.alu_lt, io.alu_ltu,
                  io.out_pc, io.out_rd, io.out_wb_en, io.out_is_load);
      end
      rst_n = 1'b1;
      step();
      #1;
      checks++;
      if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release out_valid=%b in_ready=%b required 0/1", io.out_valid, io.in_ready);
      end
   endtask

   task automatic test_capture();
      drive(32'h100, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      sbq.push_back(make_exp(32'd5, 32'd7, 3'b000, 1'b0, 1'b0, 32'h100, 5'd5, 1'b1, 1'b0));
      step();
      io.in_valid = 1'b0;
      #1;
      checks++;
      if (io.out_valid !== 1'b1 || io.alu_a !== 32'd5 || io.alu_b !== 32'd7 || io.alu_control !== 1'b0) begin
         errors++;
         $display("FAIL capture out_valid=%b a=%h b=%h ctl=%b required 1/5/7/0",
                  io.out_valid, io.alu_a, io.alu_b, io.alu_control);
      end
      step();
      #1;
      checks++;
      if (io.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL capture_drain out_valid=%b required 0", io.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      drive(32'h104, 5'd1, 5'd0, 5'd6, 32'd10, 32'h0, 32'h400, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0);
      sbq.push_back(make_exp(32'd10, 32'h400, 3'b000, 1'b1, 1'b1, 32'h104, 5'd6, 1'b1, 1'b0));
      step();
      drive(32'h108, 5'd3, 5'd2, 5'd7, 32'h0, 32'h1, 32'h0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
      exm_wb_en  = 1'b1;
      exm_rd     = 5'd3;
      exm_result = 32'hFFFF_FFFF;
      sbq.push_back(make_exp(32'hFFFF_FFFF, 32'h1, 3'b000, 1'b1, 1'b0, 32'h108, 5'd7, 1'b1, 1'b0));
      #1;
      checks++;
      if (io.out_valid !== 1'b1 || io.in_ready !== 1'b1 || io.alu_control !== 1'b0) begin
         errors++;
         $display("FAIL addi_guard out_valid=%b in_ready=%b ctl=%b required 1/1/0",
                  io.out_valid, io.in_ready, io.alu_control);
      end
      step();
      io.in_valid = 1'b0;
      bus_clear();
      #1;
      checks++;
      if (io.alu_a !== 32'hFFFF_FFFF || io.alu_control !== 1'b1 || io.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL exm_fwd_sub a=%h ctl=%b out_valid=%b required ffffffff/1/1",
                  io.alu_a, io.alu_control, io.out_valid);
      end
      step();
   endtask

   task automatic test_slt_priority();
      drive(32'h10C, 5'd6, 5'd7, 5'd8, 32'h0, 32'h1, 32'h0, 1'b0, 3'b010, 1'b0, 1'b1, 1'b1);
      exm_wb_en  = 1'b1;
      exm_rd     = 5'd6;
      exm_result = 32'hFFFF_FFFE;
      mwb_wb_en  = 1'b1;
      mwb_rd     = 5'd6;
      mwb_result = 32'h3;
      sbq.push_back(make_exp(32'hFFFF_FFFE, 32'h1, 3'b010, 1'b0, 1'b0, 32'h10C, 5'd8, 1'b1, 1'b1));
      step();
      io.in_valid = 1'b0;
      bus_clear();
      #1;
      checks++;
      if (io.alu_a !== 32'hFFFF_FFFE || io.alu_lt !== 1'b1 || io.alu_ltu !== 1'b0) begin
         errors++;
         $display("FAIL slt_split a=%h lt=%b ltu=%b required fffffffe/1/0", io.alu_a, io.alu_lt, io.alu_ltu);
      end
      step();
   endtask

   task automatic test_fwd_both();
      drive(32'h110, 5'd8, 5'd9, 5'd10, 32'h1, 32'h2, 32'h0, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0);
      exm_wb_en  = 1'b1;
      exm_rd     = 5'd8;
      exm_result = 32'h0F0F;
      mwb_wb_en  = 1'b1;
      mwb_rd     = 5'd9;
      mwb_result = 32'h00FF;
      sbq.push_back(make_exp(32'h0F0F, 32'h00FF, 3'b111, 1'b0, 1'b0, 32'h110, 5'd10, 1'b1, 1'b0));
      step();
      io.in_valid = 1'b0;
      bus_clear();
      #1;
      checks++;
      if (io.alu_a !== 32'h0F0F || io.alu_b !== 32'h00FF) begin
         errors++;
         $display("FAIL fwd_both a=%h b=%h required 00000f0f/000000ff", io.alu_a, io.alu_b);
      end
      step();
   endtask

   task automatic test_x0();
      drive(32'h114, 5'd0, 5'd0, 5'd11, 32'h777, 32'h888, 32'h5, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
      exm_wb_en   = 1'b1;
      exm_rd      = 5'd0;
      exm_result  = 32'h1234;
      exm_data_ok = 1'b0;
      mwb_wb_en   = 1'b1;
      mwb_rd      = 5'd0;
      mwb_result  = 32'h5678;
      sbq.push_back(make_exp(32'h0, 32'h5, 3'b000, 1'b0, 1'b1, 32'h114, 5'd11, 1'b1, 1'b0));
      step();
      io.in_valid = 1'b0;
      #1;
      checks++;
      if (io.alu_a !== 32'h0 || io.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL x0_no_fwd a=%h out_valid=%b required 0/1", io.alu_a, io.out_valid);
      end
      step();
      bus_clear();
   endtask

   task automatic test_load_use();
      drive(32'h118, 5'd1, 5'd4, 5'd9, 32'h3, 32'h11, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      sbq.push_back(make_exp(32'h3, 32'hAA, 3'b000, 1'b0, 1'b0, 32'h118, 5'd9, 1'b1, 1'b0));
      step();
      io.in_valid = 1'b0;
      exm_wb_en   = 1'b1;
      exm_rd      = 5'd4;
      exm_result  = 32'hDEAD;
      exm_data_ok = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (io.out_valid !== 1'b0 || io.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall cycle=%0d out_valid=%b in_ready=%b required 0/0",
                     i, io.out_valid, io.in_ready);
         end
         step();
      end
      exm_data_ok = 1'b1;
      exm_result  = 32'hAA;
      #1;
      checks++;
      if (io.out_valid !== 1'b1 || io.alu_b !== 32'hAA) begin
         errors++;
         $display("FAIL load_use_release out_valid=%b b=%h required 1/000000aa", io.out_valid, io.alu_b);
      end
      step();
      bus_clear();
      #1;
      checks++;
      if (io.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL load_use_drain out_valid=%b required 0", io.out_valid);
      end
   endtask

   task automatic test_flush_backpressure();
      io.out_ready = 1'b0;
      drive(32'h11C, 5'd5, 5'd2, 5'd10, 32'h1, 32'h7, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      step();
      io.in_valid = 1'b0;
      mwb_wb_en  = 1'b1;
      mwb_rd     = 5'd5;
      mwb_result = 32'h99;
      #1;
      checks++;
      if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_hold out_valid=%b in_ready=%b required 1/0", io.out_valid, io.in_ready);
      end
      step();
      bus_clear();
      #1;
      checks++;
      if (io.alu_a !== 32'h99 || io.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_snoop a=%h in_ready=%b required 00000099/0", io.alu_a, io.in_ready);
      end
      step();
      #1;
      checks++;
      if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0 || io.out_pc !== 32'h11C) begin
         errors++;
         $display("FAIL bp_third out_valid=%b in_ready=%b pc=%h required 1/0/0000011c",
                  io.out_valid, io.in_ready, io.out_pc);
      end
      flush = 1'b1;
      drive(32'h200, 5'd1, 5'd2, 5'd12, 32'h4, 32'h4, 32'h0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      step();
      flush = 1'b0;
      io.in_valid = 1'b0;
      #1;
      checks++;
      if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 || io.out_pc !== 32'h11C) begin
         errors++;
         $display("FAIL flush_drop out_valid=%b in_ready=%b pc=%h required 0/1/0000011c",
                  io.out_valid, io.in_ready, io.out_pc);
      end
      step();
      #1;
      checks++;
      if (io.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty out_valid=%b required 0", io.out_valid);
      end
      io.out_ready = 1'b1;
   endtask

   task automatic test_reset_mid_stall();
      drive(32'h120, 5'd3, 5'd0, 5'd13, 32'h1, 32'h0, 32'h2, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
      step();
      io.in_valid = 1'b0;
      exm_wb_en   = 1'b1;
      exm_rd      = 5'd3;
      exm_result  = 32'h55;
      exm_data_ok = 1'b0;
      #1;
      checks++;
      if (io.out_valid !== 1'b0 || io.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_stall out_valid=%b in_ready=%b required 0/0", io.out_valid, io.in_ready);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus_clear();
      #1;
      checks++;
      if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 || io.alu_a !== 32'h0 || io.out_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_discard out_valid=%b in_ready=%b a=%h pc=%h required 0/1/0/0",
                  io.out_valid, io.in_ready, io.alu_a, io.out_pc);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_capture();
      test_back_to_back();
      test_slt_priority();
      test_fwd_both();
      test_x0();
      test_load_use();
      test_flush_backpressure();
      test_reset_mid_stall();
      step();
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover pending=%0d required 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/idex_stage.md
# idex_stage

ID/EX pipeline register for the RV32I core, sitting directly upstream of the ALU. Captures one decoded instruction per handshake, resolves operands by forwarding from EX/MEM and MEM/WB, and stalls on load-use hazards. Computes the `lt`/`ltu` flags the ALU consumes, then presents registered operands, funct3 and the control bit with valid/ready flow control.

## Interface
- No parameters. XLEN is fixed at 32 and the register index width at 5.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` / `in_ready` in / out 1: handshake from decode.
- `in_pc` in 32.
- `in_rs1`, `in_rs2`, `in_rd` in 5 each.
- `in_rs1_val`, `in_rs2_val` in 32 each: register-file read data.
- `in_imm` in 32.
- `in_use_imm` in 1: 1 selects the immediate for operand b.
- `in_funct3` in 3.
- `in_b30` in 1: instruction bit 30.
- `in_wb_en` in 1; `in_is_load` in 1.
- `exm_wb_en` in 1, `exm_rd` in 5, `exm_result` in 32, `exm_data_ok` in 1: EX/MEM forward bus. `exm_data_ok`=0 means the load data is not yet available.
- `mwb_wb_en` in 1, `mwb_rd` in 5, `mwb_result` in 32: MEM/WB forward bus and register-file write.
- `flush` in 1: kill the held instruction.
- `out_valid` / `out_ready` out / in 1: handshake to execute.
- `alu_a`, `alu_b` out 32 each: resolved operands.
- `alu_op` out 3: funct3.
- `alu_control` out 1.
- `alu_lt`, `alu_ltu` out 1 each.
- `out_pc` out 32, `out_rd` out 5, `out_wb_en` out 1, `out_is_load` out 1.

## Operation
- **Storage.** One entry: `valid_q`, the captured fields, and stored operand values `r1_q` / `r2_q`.
- **Capture.** A capture occurs when `in_valid && in_ready && !flush`.
- **Forwarding.** Forwarding occurs at capture time and again on every held cycle.
  - Source = rs (5 bits) → value chosen by priority: EX/MEM (`exm_wb_en`, `exm_rd`==rs) > MEM/WB (`mwb_wb_en`, `mwb_rd`==rs) > stored or register-file value.
  - rs==0 always yields 0 and never matches a forward bus.
- **Snoop while held.** On every cycle with `valid_q`=1 and no capture, `r1_q`/`r2_q` are overwritten when MEM/WB writes the matching rs. This keeps a stalled entry coherent after the producer retires.
- **Operand select.**
  - `alu_a` = forwarded rs1.
  - `alu_b` = `imm_q` when `use_imm_q`, else forwarded rs2.
- **Compares.**
  - `alu_lt` = signed(`alu_a`) < signed(`alu_b`).
  - `alu_ltu` = unsigned compare of the same operands.
  - Both are computed on the post-forwarding operands.
- **Control bit.** `alu_control` = `b30_q` when (`!use_imm_q`) or (`funct3_q`==3'b101); otherwise 0. This blocks a bogus subtract on ADDI with imm[10] set.
- **Hazard.** `hz` = `valid_q` && `exm_wb_en` && !`exm_data_ok` && `exm_rd`≠0 && (`exm_rd`==rs1 || (!`use_imm_q` && `exm_rd`==rs2)).
- **State** (derived from `valid_q` and `hz`):
  - EMPTY: `valid_q`=0.
  - HOLD: `valid_q`=1, `hz`=0, so `out_valid`=1.
  - WAIT: `valid_q`=1, `hz`=1, so `out_valid`=0.
  - Transitions:
    - EMPTY→HOLD/WAIT on capture.
    - HOLD→EMPTY on `out_ready` with no capture.
    - HOLD→HOLD/WAIT on `out_ready` with capture.
    - WAIT→HOLD when `exm_data_ok` rises.
    - Any state→EMPTY on `flush`.
- **Handshake.** `out_valid` = `valid_q` && !`hz`. `in_ready` = !`valid_q` || (`out_valid` && `out_ready`).
- **Flush.** Clears `valid_q` next cycle. A same-cycle incoming instruction is dropped and `in_ready` is ignored.

## Timing
- Latency is 1 cycle: an instruction captured at edge N is presented with `out_valid` after N, provided there is no hazard.
- Throughput is 1 instruction/cycle with `out_ready` held high and no hazards.
- Output paths are combinational from registers and the forward buses: compares, forwarding muxes and `out_valid`.
- The EX/MEM → `alu_a` path is single-cycle combinational.
- Reset values:
  - `valid_q`=0, so `out_valid`=0 and `in_ready`=1.
  - All stored fields are 0, so `alu_a`/`alu_b`=0, `alu_op`=0, `alu_control`=0, `alu_lt`=0, `alu_ltu`=0, `out_pc`=0, `out_rd`=0, `out_wb_en`=0, `out_is_load`=0.
- Reset asserted mid-stall discards the entry.
- Both forward buses matching the same rs: EX/MEM wins.
- Both buses matching rs1 and rs2 respectively: each operand resolves independently.

## Structure
- Shared package `r200_pkg` holds:
  - funct3 constants: ADD=000, SLL=001, SLT=010, SLTU=011, XOR=100, SR=101, OR=110, AND=111.
  - `XLEN`=32.
  - `REGW`=5.
- Sub-module `operand_fwd`, instantiated twice (rs1, rs2).
  - Inputs: rs, base value, both forward buses.
  - Outputs: resolved value, `match_exm`, `match_mwb`.
  - Purely combinational.

## Test plan
- **Capture and present.** Reset, then capture ADD rs1=1 (val 5), rs2=2 (val 7), `out_ready`=1 → next cycle: `alu_a`=5, `alu_b`=7, `alu_op`=000, `alu_control`=0, `out_valid`=1.
- **EX/MEM forward and ADDI guard.** ADDI with imm=0x400, `in_b30`=1 → `alu_control`=0. Then SUB with rs1=3 while EX/MEM writes x3=0xFFFFFFFF → `alu_a`=0xFFFFFFFF, `alu_control`=1.
- **SLT/SLTU split.** SLT `alu_a`=0xFFFFFFFE (-2), `alu_b`=1 → `alu_lt`=1, `alu_ltu`=0.
- **x0 never forwarded.** rs1=0 with EX/MEM writing rd=0 value 0x1234 → `alu_a`=0.
- **Load-use stall.** Held rs2=4, `exm_rd`=4, `exm_data_ok`=0 for 2 cycles → `out_valid`=0 and `in_ready`=0 for 2 cycles. On `exm_data_ok`=1 with `exm_result`=0xAA → `alu_b`=0xAA, `out_valid`=1.
- **Flush and backpressure.** Backpressure `out_ready`=0 for 3 cycles → entry held, `in_ready`=0. Then `flush` together with `in_valid` → next cycle `out_valid`=0, the new instruction is not captured, `in_ready`=1.
